unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch requester (IF) and the load/store requester (D) of a multicycle/stalling core.
- Sequences each access through issue, wait and done phases, returns registered read data, and drives a core-wide stall.
- Sits between the PC/fetch logic, the load/store path, and the memory macro.

Parameters:
- WIDTH, 32, data/address width
- LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the clock edge)
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  WIDTH  fetch byte address
- if_rdata  out  WIDTH  fetched instruction
- if_ready  out  1  one-cycle completion pulse for the fetch
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_mode  in  3  byte/half/word/unsigned mode, passed through to memory
- d_addr  in  WIDTH  data byte address
- d_wdata  in  WIDTH  store data
- d_rdata  out  WIDTH  load data
- d_ready  out  1  one-cycle completion pulse for the data access
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable
- mem_mode  out  3  access mode
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data
- stall  out  1  core stall

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. A wait counter cnt is 4 bits wide. An owner flag own records the granted requester (0=IF, 1=D).
- Reset (rst=0 at a clock edge):
  - State goes to IDLE, cnt=0, own=0.
  - mem_en=0, mem_we=0, mem_mode=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - Reset mid-access abandons the access; no ready pulse is generated for it.
- IDLE:
  - If d_req=1, grant D. Data has fixed priority because it belongs to the older instruction.
  - Else if if_req=1, grant IF.
  - On a grant, register the address, write enable, mode and write data of the winner onto the mem_* outputs. Set mem_en=1 and mem_we=d_we (mem_we=0 for IF). Go to ISSUE.
  - With no request, stay in IDLE with mem_en=0.
- ISSUE: mem_en is high for exactly this cycle. cnt loads LATENCY-1. Next state is WAIT, or directly a capture if LATENCY=1.
- WAIT: cnt decrements each cycle. mem_en=0 and mem_we=0. The mem_addr, mem_mode and mem_wdata registers hold their values.
- Capture: in the cycle where mem_rdata is valid (ISSUE cycle + LATENCY), register mem_rdata into the owner's rdata register. Go to DONE.
- DONE: the owner's ready output is 1 for exactly this cycle. Requests are not sampled in DONE. Next state is IDLE.
- Latency: a request first seen in IDLE at cycle t gets ready at cycle t+2+LATENCY. The next grant is sampled at t+3+LATENCY. Peak throughput is one access per LATENCY+3 cycles.
- Stores follow the same schedule. For a store, d_rdata is still loaded with mem_rdata, and its value is don't-care.
- if_rdata and d_rdata hold their value until the next capture for the same owner.
- Dropping a request mid-access: the access still completes and its ready still pulses. The arbiter does not re-sample inputs after the grant.
- Simultaneous if_req and d_req in IDLE: D is served first. IF is served starting in the IDLE cycle after D's DONE, provided if_req is still high.
- stall is combinational: (if_req & ~if_ready) | (d_req & ~d_ready). It is 0 in the ready cycle of the last pending requester.
- Requester contract: hold req and all request fields stable until ready. A requester may re-assert req in the cycle after ready.

Test Plan:
- Fetch read, LATENCY=2, rst released, if_req=1 with if_addr=0x10 at cycle 0, memory returns 0x00500093 at cycle 3 → mem_en=1 with mem_addr=0x10 only at cycle 1; if_ready=1 and if_rdata=0x00500093 at cycle 4; stall=1 for cycles 0..3.
- Simultaneous requests: if_req=1 (0x14) and d_req=1 (load, 0x100) at cycle 0 → mem_addr=0x100 at cycle 1, d_ready at cycle 4; mem_addr=0x14 at cycle 6, if_ready at cycle 9.
- Store: d_we=1, d_mode=3'b010, d_addr=0x200, d_wdata=0xDEADBEEF → for one cycle, mem_en=1, mem_we=1, mem_mode=3'b010, mem_wdata=0xDEADBEEF; d_ready pulses 4 cycles after the request; if_ready is never asserted.
- Reset mid-access: rst=0 at the WAIT cycle → the next cycle shows IDLE with every output 0; no ready pulse; a new if_req after rst=1 completes normally.
- LATENCY=1 build: d_req at cycle 0 → mem_en at cycle 1, capture at cycle 2, d_ready at cycle 3; back-to-back held requests are granted every 4 cycles.
- Request dropped after grant: d_req deasserted at cycle 2 → d_ready still pulses at cycle 4; no second mem_en.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-port memory between fetch and load/store,
// with data given priority and a core-wide stall while any request is outstanding.
module unified_mem_arbiter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_ready,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [2:0]       d_mode,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_ready,
   output logic             mem_en,
   output logic             mem_we,
   output logic [2:0]       mem_mode,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             stall
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic own_q, own_d;
   logic en_q, en_d, we_q, we_d;
   logic [2:0] mode_q, mode_d;
   logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic if_ready_q, if_ready_d, d_ready_q, d_ready_d;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         own_q      <= 1'b0;
         en_q       <= 1'b0;
         we_q       <= 1'b0;
         mode_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         own_q      <= own_d;
         en_q       <= en_d;
         we_q       <= we_d;
         mode_q     <= mode_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ready_q <= if_ready_d;
         d_ready_q  <= d_ready_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      own_d      = own_q;
      en_d       = 1'b0;
      we_d       = 1'b0;
      mode_d     = mode_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ready_d = 1'b0;
      d_ready_d  = 1'b0;
      case (state_q)
         IDLE: if (d_req || if_req) begin
            own_d   = d_req;
            en_d    = 1'b1;
            we_d    = d_req & d_we;
            mode_d  = d_req ? d_mode : 3'd0;
            addr_d  = d_req ? d_addr : if_addr;
            wdata_d = d_req ? d_wdata : '0;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
         end
         // cnt reaches zero exactly in the cycle mem_rdata becomes valid
         WAIT: if (cnt_q == 4'd0) begin
            if_rdata_d = own_q ? if_rdata_q : mem_rdata;
            d_rdata_d  = own_q ? mem_rdata : d_rdata_q;
            if_ready_d = !own_q;
            d_ready_d  = own_q;
            state_d    = DONE;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         DONE: state_d = IDLE;
      endcase
   end
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_mode  = mode_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_ready  = if_ready_q;
   assign d_ready   = d_ready_q;
   assign stall     = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of the arbiter at LATENCY=2 and LATENCY=1 against
// a fixed-latency memory model and a queue of expected completions.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0, vectors = 0, miscompares = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic if_req = 0, d_req = 0, d_we = 0;
   logic [2:0] d_mode = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic if_ready, d_ready, mem_en, mem_we, stall;
   logic [2:0] mem_mode;

   logic b_if_req = 0, b_d_req = 0, b_d_we = 0;
   logic [2:0] b_d_mode = 0;
   logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
   logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic b_if_ready, b_d_ready, b_mem_en, b_mem_we, b_stall;
   logic [2:0] b_mem_mode;

   unified_mem_arbiter #(.WIDTH(32), .LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .mem_en(mem_en),
      .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall));

   unified_mem_arbiter #(.WIDTH(32), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
      .if_ready(b_if_ready), .d_req(b_d_req), .d_we(b_d_we), .d_mode(b_d_mode),
      .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ready(b_d_ready),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_mode(b_mem_mode), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .stall(b_stall));

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a == 32'h10) ? 32'h00500093 : (a ^ 32'hA5A50000);
   endfunction

   // memory models: read data is valid only LATENCY cycles after the mem_en cycle
   logic pv0 = 0, pv1 = 0, pbv = 0, st_v = 0;
   logic [31:0] pa0 = 0, pa1 = 0, pba = 0, st_a = 0, st_d = 0;
   always @(posedge clk) begin
      pv0 <= mem_en;
      pa0 <= mem_addr;
      pv1 <= pv0;
      pa1 <= pa0;
      pbv <= b_mem_en;
      pba <= b_mem_addr;
      if (mem_en && mem_we) begin
         st_v <= 1'b1;
         st_a <= mem_addr;
         st_d <= mem_wdata;
      end
   end
   assign mem_rdata = !pv1 ? 32'hBAD0BAD0 : (st_v && pa1 == st_a) ? st_d : pat(pa1);
   assign b_mem_rdata = pbv ? pat(pba) : 32'hBAD0BAD0;

   typedef struct {logic own; logic [31:0] data; int cyc; logic has_data;} exp_t;
   exp_t sb_a[$], sb_b[$];
   exp_t ea, eb;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (if_ready || d_ready) begin
      chk("a_ready_expected", 64'(sb_a.size() > 0), 1);
      chk("a_single_ready", 64'(if_ready & d_ready), 0);
      if (sb_a.size() > 0) begin
         ea = sb_a.pop_front();
         chk("a_ready_owner", 64'(d_ready), 64'(ea.own));
         chk("a_ready_cycle", 64'(cyc), 64'(ea.cyc));
         if (ea.has_data) chk("a_rdata", d_ready ? d_rdata : if_rdata, ea.data);
      end
   end

   always @(negedge clk) if (b_if_ready || b_d_ready) begin
      chk("b_ready_expected", 64'(sb_b.size() > 0), 1);
      chk("b_if_ready_never", 64'(b_if_ready), 0);
      if (sb_b.size() > 0) begin
         eb = sb_b.pop_front();
         chk("b_ready_cycle", 64'(cyc), 64'(eb.cyc));
         chk("b_rdata", b_d_rdata, eb.data);
      end
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_mode", mem_mode, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_b_mem_en", b_mem_en, 0);
      rst = 1'b1;

      // fetch read
      @(posedge clk); #1;
      base = cyc; if_req = 1; if_addr = 32'h10;
      sb_a.push_back('{1'b0, 32'h00500093, base + 4, 1'b1});
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("t1_mem_en", mem_en, 64'(k == 1));
         if (k == 1) chk("t1_mem_addr", mem_addr, 32'h10);
         chk("t1_stall", stall, 64'(k <= 3));
         if (k == 4) if_req = 0;
      end

      // simultaneous requests: data wins
      @(posedge clk); #1;
      base = cyc; if_req = 1; if_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h100;
      sb_a.push_back('{1'b1, pat(32'h100), base + 4, 1'b1});
      sb_a.push_back('{1'b0, pat(32'h14), base + 9, 1'b1});
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         chk("t2_mem_en", mem_en, 64'(k == 1 || k == 6));
         if (k == 1) chk("t2_mem_addr_d", mem_addr, 32'h100);
         if (k == 6) chk("t2_mem_addr_if", mem_addr, 32'h14);
         chk("t2_stall", stall, 64'(k < 9));
         if (k == 4) d_req = 0;
         if (k == 9) if_req = 0;
      end

      // store
      @(posedge clk); #1;
      base = cyc; d_req = 1; d_we = 1; d_mode = 3'b010; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      sb_a.push_back('{1'b1, 32'h0, base + 4, 1'b0});
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("t3_mem_en", mem_en, 64'(k == 1));
         chk("t3_mem_we", mem_we, 64'(k == 1));
         if (k == 1) begin
            chk("t3_mem_mode", mem_mode, 3'b010);
            chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("t3_mem_addr", mem_addr, 32'h200);
         end
         chk("t3_if_ready", if_ready, 0);
         if (k == 4) begin d_req = 0; d_we = 0; d_mode = 0; d_wdata = 0; end
      end

      // load of the stored word, request dropped after grant
      @(posedge clk); #1;
      base = cyc; d_req = 1; d_addr = 32'h200;
      sb_a.push_back('{1'b1, 32'hDEADBEEF, base + 4, 1'b1});
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         chk("t6_mem_en", mem_en, 64'(k == 1));
         if (k == 2) d_req = 0;
      end

      // reset in the WAIT cycle abandons the access
      @(posedge clk); #1;
      base = cyc; if_req = 1; if_addr = 32'h10;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k == 2) begin rst = 0; if_req = 0; end
         if (k == 3) begin
            chk("t4_mem_en", mem_en, 0);
            chk("t4_mem_addr", mem_addr, 0);
            chk("t4_mem_mode", mem_mode, 0);
            chk("t4_mem_wdata", mem_wdata, 0);
            chk("t4_if_rdata", if_rdata, 0);
            chk("t4_d_rdata", d_rdata, 0);
            chk("t4_stall", stall, 0);
            rst = 1;
         end
         if (k >= 3) chk("t4_no_ready", 64'(if_ready | d_ready), 0);
      end
      @(posedge clk); #1;
      base = cyc; if_req = 1; if_addr = 32'h14;
      sb_a.push_back('{1'b0, pat(32'h14), base + 4, 1'b1});
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         chk("t4_post_stall", stall, 64'(k <= 3));
         if (k == 4) if_req = 0;
      end

      // LATENCY=1 instance: held request granted every 4 cycles
      @(posedge clk); #1;
      base = cyc; b_d_req = 1; b_d_addr = 32'h30;
      sb_b.push_back('{1'b1, pat(32'h30), base + 3, 1'b1});
      sb_b.push_back('{1'b1, pat(32'h30), base + 7, 1'b1});
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         chk("t5_mem_en", b_mem_en, 64'(k == 1 || k == 5));
         chk("t5_d_ready", b_d_ready, 64'(k == 3 || k == 7));
         if (k == 7) b_d_req = 0;
      end

      repeat (2) @(negedge clk);
      chk("sb_a_drained", 64'(sb_a.size()), 0);
      chk("sb_b_drained", 64'(sb_b.size()), 0);
      chk("b_if_rdata", b_if_rdata, 0);
      chk("b_mem_we", b_mem_we, 0);
      chk("b_mem_mode", b_mem_mode, 0);
      chk("b_mem_wdata", b_mem_wdata, 0);
      chk("b_stall", b_stall, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
